register_file_wb: RTL

- Architectural integer register file for the 5-stage RV32I pipeline.
- Receives and commits the writeback-stage result: ResultW goes to register RdW when RegWriteW is high.
- Serves the two decode-stage source operands.
- Keeps a committed-write counter for retire accounting and debug.

---
 rtl/rv_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 39 +++
 rtl/register_file_wb.sv | 66 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants and types for the integer register file.
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, x0 forced to zero and, when
// REGFILE_BYPASS_EN is defined, a write-first bypass of the writeback result.
module regfile_read_port
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = rv_pkg::AW
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]              An,
  input  logic                       RegWriteW,
  input  logic [AW-1:0]              RdW,
  input  logic [XLEN-1:0]            ResultW,
  output logic [XLEN-1:0]            RDn
);

`ifdef REGFILE_BYPASS_EN
  // x0 reads zero; a same-cycle commit to An is forwarded ahead of storage
  always_comb begin
    RDn = '0;
    if (An != '0) begin
      RDn = regs[An];
      if (RegWriteW && (RdW == An)) RDn = ResultW;
    end
  end
`else
  // read-old build: writeback signals only matter for the bypass
  logic unused_wb;
  assign unused_wb = ^{RegWriteW, RdW, ResultW};

  // x0 reads zero; otherwise the stored value
  always_comb begin
    RDn = '0;
    if (An != '0) RDn = regs[An];
  end
`endif

endmodule

// File: rtl/register_file_wb.sv
// RV32I architectural register file: one writeback write port, two decode
// read ports and a committed-write counter.
// Optional feature macro: REGFILE_BYPASS_EN (write-first bypass on reads).
module register_file_wb
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = rv_pkg::AW,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [CNTW-1:0] WrCount
);

  logic [XLEN-1:0]              mem [1:NREGS-1];
  logic [NREGS-1:0][XLEN-1:0]   regs;
  logic [CNTW-1:0]              wr_count;
  logic                         commit;
  logic                         byp_we;

  // x0 writes are dropped; an X enable compares false and commits nothing
  assign commit = (RegWriteW == 1'b1) && (RdW != REG_ZERO);
  // no forwarding while held in reset so reads stay at zero
  assign byp_we = RegWriteW && rst_n;

  // storage x1..x(NREGS-1); x0 has no flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[RdW] <= ResultW;
    end
  end

  // committed-write counter, wraps modulo 2^CNTW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_count <= '0;
    else if (commit) wr_count <= wr_count + 1'b1;
  end

  // flatten storage for the read ports, x0 slot tied to zero
  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < NREGS; i++) regs[i] = mem[i];
  end

  assign WrCount = wr_count;

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rp1 (
    .regs(regs), .An(A1), .RegWriteW(byp_we), .RdW(RdW), .ResultW(ResultW), .RDn(RD1)
  );

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rp2 (
    .regs(regs), .An(A2), .RegWriteW(byp_we), .RdW(RdW), .ResultW(ResultW), .RDn(RD2)
  );

endmodule
